// File: rtl/fp16_mul_norm_round_if.sv
// Handshake/data bundle for the FP16 multiplier normalize/round stage.
// master = producer/consumer side (bench), slave = the stage itself.
interface fp16_mul_norm_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic        in_zero;
  logic [5:0]  in_exp_sum;
  logic [21:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_ovf;
  logic        out_unf;

  modport master (
    output in_valid, in_sign, in_zero, in_exp_sum, in_prod, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_sign, in_zero, in_exp_sum, in_prod, out_ready,
    output in_ready, out_valid, out_result, out_ovf, out_unf
  );
endinterface

// File: rtl/fp16_mul_norm_round.sv
// FP16 multiply back end: normalize (stage 1), round/range-check/pack (stage 2).
// FP_MUL_RNE_EN selects round-to-nearest-even; undefined means truncation.
module fp16_mul_norm_round #(
  parameter int BIAS    = 15,
  parameter int EXP_MAX = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  fp16_mul_norm_round_if.slave bus
);
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic signed [7:0] e;
    logic [9:0]        frac;
    logic              g;
    logic              s;
  } norm_t;

  localparam logic signed [7:0] EMAX_S = 8'(EXP_MAX);

  logic [2:1]        r_vld_pipe;
  norm_t             r_s1, w_norm;
  logic              w_s2_adv, w_in_fire;
  logic [15:0]       r_result, w_result;
  logic              r_ovf, r_unf, w_ovf, w_unf;
  logic [9:0]        w_frac_o;
  logic signed [7:0] w_e2;

  assign w_s2_adv     = !r_vld_pipe[2] | bus.out_ready;
  assign bus.in_ready = !r_vld_pipe[1] | w_s2_adv;
  assign w_in_fire    = bus.in_valid & bus.in_ready;

  assign bus.out_valid  = r_vld_pipe[2];
  assign bus.out_result = r_result;
  assign bus.out_ovf    = r_ovf;
  assign bus.out_unf    = r_unf;

  // Product is 1x.xxx or 1.xxx; bit 21 says which, and bumps the exponent.
  always_comb begin
    w_norm      = '0;
    w_norm.sign = bus.in_sign;
    w_norm.zero = bus.in_zero;
    if (bus.in_prod[21]) begin
      w_norm.frac = bus.in_prod[20:11];
      w_norm.g    = bus.in_prod[10];
      w_norm.s    = |bus.in_prod[9:0];
    end else begin
      w_norm.frac = bus.in_prod[19:10];
      w_norm.g    = bus.in_prod[9];
      w_norm.s    = |bus.in_prod[8:0];
    end
    w_norm.e = {2'b00, bus.in_exp_sum} - 8'(BIAS) + {7'd0, bus.in_prod[21]};
  end

`ifdef FP_MUL_RNE_EN
  logic        w_inc;
  logic [10:0] w_frac_r;
  assign w_inc    = r_s1.g & (r_s1.s | r_s1.frac[0]);
  assign w_frac_r = {1'b0, r_s1.frac} + {10'd0, w_inc};
  // Mantissa overflow after rounding lands exactly on the next power of two.
  assign w_frac_o = w_frac_r[10] ? 10'd0 : w_frac_r[9:0];
  assign w_e2     = r_s1.e + $signed({7'd0, w_frac_r[10]});
`else
  logic w_unused_gs;
  assign w_unused_gs = r_s1.g ^ r_s1.s;
  assign w_frac_o    = r_s1.frac;
  assign w_e2        = r_s1.e;
`endif

  always_comb begin
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    w_result = {r_s1.sign, w_e2[4:0], w_frac_o};
    if (r_s1.zero) begin
      w_result = {r_s1.sign, 15'h0};
    end else if (w_e2 >= EMAX_S) begin
      w_result = {r_s1.sign, 5'h1F, 10'h0};
      w_ovf    = 1'b1;
    end else if (w_e2 <= 8'sd0) begin
      w_result = {r_s1.sign, 15'h0};
      w_unf    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      if (bus.in_ready) begin
        r_vld_pipe[1] <= bus.in_valid;
        if (w_in_fire) r_s1 <= w_norm;
      end
      if (w_s2_adv) begin
        r_vld_pipe[2] <= r_vld_pipe[1];
        if (r_vld_pipe[1]) begin
          r_result <= w_result;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
        end
      end
    end
  end
endmodule

// File: doc/fp16_mul_norm_round.md
Name: fp16_mul_norm_round

Overview:
Downstream stage of the half-precision (FP16) multiplier datapath. It consumes the raw sign, biased exponent sum and 22-bit significand product produced by the multiplier core. It then normalizes, rounds and range-checks them, and emits the packed 16-bit IEEE-754 binary16 result.
- 2-stage registered pipeline with valid/ready handshake on both sides.
- Overflow and underflow flags accompany each result.

Parameters:
BIAS, 15, exponent bias subtracted from the exponent sum.
EXP_MAX, 31, all-ones exponent code; a result exponent >= EXP_MAX saturates to infinity.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream operand-product valid
in_ready  output  1  stage can accept the input this cycle
in_sign  input  1  result sign (sign_a XOR sign_b)
in_zero  input  1  either operand is zero
in_exp_sum  input  6  exp_a + exp_b, both biased, unsigned
in_prod  input  22  {1,frac_a} * {1,frac_b}, unsigned
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_result  output  16  packed FP16 {sign, exp[4:0], frac[9:0]}
out_ovf  output  1  result saturated to infinity
out_unf  output  1  result flushed to zero

Behaviour:
- Reset (rst=1 at a clk edge):
  - s1_valid=0, out_valid=0, out_result=16'h0000, out_ovf=0, out_unf=0.
  - Reset mid-operation discards both pipeline stages.
  - in_ready=1 in the cycle after reset.
- Handshake:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = s2_adv.
  - in_ready = !s1_valid | s2_adv (combinational).
  - A transfer occurs when in_valid & in_ready.
  - Outputs hold stable while out_valid & !out_ready.
  - Full throughput: 1 result per cycle when out_ready stays high.
- Latency: 2 cycles from the input transfer to out_valid.
- Stage 1 (normalize), registered on input transfer:
  - If in_prod[21]=1: frac=in_prod[20:11], G=in_prod[10], S=|in_prod[9:0], e=in_exp_sum-BIAS+1.
  - Else: frac=in_prod[19:10], G=in_prod[9], S=|in_prod[8:0], e=in_exp_sum-BIAS.
  - e is held as an 8-bit signed value.
  - sign and zero are carried forward.
- Stage 2 (round/pack):
  - inc = G & (S | frac[0]), round-to-nearest-even; see Optional Feature.
  - frac_r = frac + inc, 11-bit.
  - Carry out (frac_r[10]=1): frac=0, e=e+1.
  - zero=1: result={sign,15'h0}, ovf=0, unf=0. Takes precedence over all other cases.
  - e >= EXP_MAX: result={sign,5'h1F,10'h0}, ovf=1.
  - e <= 0: result={sign,15'h0}, unf=1. Subnormals are not produced.
  - Otherwise: result={sign,e[4:0],frac_r[9:0]}, flags 0.
- in_prod[21:20]=00 is illegal (operands not normalized); the output in that case is don't-care.
- Inf/NaN operands are out of scope; the upstream stage guarantees finite inputs.
- Simultaneous s2 drain and s1 load in the same cycle are legal and lose no data.

Optional Feature:
Macro FP_MUL_RNE_EN.
- Defined: Stage 2 rounds to nearest even as described, and carry-out renormalization is active.
- Undefined: truncation, inc=0. The rounding adder and carry path are removed; G and S are still computed but unused.

Test Plan:
- 1.0*1.0: in_sign=0, in_exp_sum=30, in_prod=22'h100000 -> out_result=16'h3C00, flags 0, out_valid exactly 2 cycles after the transfer.
- 1.5*1.5: in_exp_sum=30, in_prod=22'h240000 -> 16'h4080 (2.25); same input with in_sign=1 -> 16'hC080.
- Rounding with FP_MUL_RNE_EN:
  - in_prod=22'h100600 -> 16'h3C02 (16'h3C01 without the macro).
  - Tie-to-even, in_prod=22'h100200 -> 16'h3C00.
  - Carry-out, in_prod=22'h1FFE00 -> 16'h4000.
- Range and zero:
  - in_exp_sum=60, in_prod=22'h100000 -> 16'h7C00 with out_ovf=1.
  - in_exp_sum=10 -> 16'h0000 with out_unf=1.
  - in_zero=1, in_sign=1 -> 16'h8000, flags 0.
- Backpressure: stream 4 back-to-back inputs, hold out_ready=0 for 3 cycles -> in_ready falls to 0 once both stages are full; out_result is held stable; all 4 results arrive in order with none lost or duplicated after out_ready=1.
- Reset mid-stream: assert rst with both stages valid -> next cycle out_valid=0, out_result=0, in_ready=1; the first post-reset input appears 2 cycles later.
